spi_control_fsm: RTL
====================

# spi_control_fsm

Transaction controller for the SPI peripheral. Watches conditioned chip-select and SCLK-rising-edge pulses, counts frame bits, decodes the read/write bit from the shift register's parallel output, and drives the control strobes:
- shift-register parallel load
- MISO buffer enable
- address latch enable
- data-memory write enable

It sits upstream of the shift register and controls when it loads; its edge-pulse input comes from the input conditioner.

## Interface
- width, 8, bits per address frame and per data frame; also the counter limit
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- sclkPosEdge  input  1  one-clk-wide pulse per conditioned SCLK rising edge; the same pulse drives the shift register's peripheralClkEdge
- chipSelect  input  1  conditioned chip select, active-low (0 = transaction active)
- readWriteBit  input  1  shift register parallelDataOut[0]; 1 = read, 0 = write
- shiftRegWriteEnable  output  1  drives shift register parallelLoad
- misoBufferEnable  output  1  tri-state enable for MISO pad
- addressLatchEnable  output  1  latches shift register contents as memory address
- dataMemWriteEnable  output  1  data memory write strobe
- state  output  3  current state encoding, for debug

## Operation
- States and encodings: IDLE=0, GET=1, GOT=2, READ_LOAD=3, READ=4, WRITE=5, WRITE_COMMIT=6, DONE=7.
- Moore outputs, decoded from the registered state only; no input-to-output combinational paths.
- Bit counter: $clog2(width+1) bits; cleared on every state entry. Increments by 1 on each sclkPosEdge in GET, READ_LOAD, READ and WRITE.
- Priority, highest first:
  - reset → IDLE, counter 0
  - chipSelect=1 → IDLE from any state, counter 0
  - normal transitions
- Transitions and outputs:
  - IDLE: all outputs 0. chipSelect=0 → GET.
  - GET: counting address bits. When the counter would reach width (i.e. on the width-th sclkPosEdge) → GOT.
  - GOT: exactly one clk. addressLatchEnable=1. readWriteBit=1 → READ_LOAD; readWriteBit=0 → WRITE.
  - READ_LOAD: shiftRegWriteEnable=1. Held until the next sclkPosEdge, on which the shift register loads; that edge counts as bit 1 → READ.
  - READ: misoBufferEnable=1. Exits → DONE on the sclkPosEdge that brings the counter to width-1 (total width edges, including the load edge).
  - WRITE: counting data bits. On the width-th sclkPosEdge → WRITE_COMMIT.
  - WRITE_COMMIT: exactly one clk. dataMemWriteEnable=1 → DONE.
  - DONE: all outputs 0. Leaves only via chipSelect=1.
- sclkPosEdge pulses in IDLE, GOT, WRITE_COMMIT and DONE are ignored: no count, no transition.
- At most one strobe output is high in any cycle.

## Timing
- Reset values: state=0 (IDLE), all four strobes 0, counter 0. Valid the clk after reset is sampled high.
- Latencies:
  - chipSelect falling to GET: 1 clk.
  - width-th address edge to addressLatchEnable: 1 clk.
  - GOT is always exactly 1 clk.
  - Last write-data edge to dataMemWriteEnable: 1 clk; strobe is exactly 1 clk wide.
- readWriteBit is sampled in GOT, one clk after the final address edge, once the shift register has updated.
- Abort: chipSelect=1 in any state returns to IDLE the next clk and drops all strobes.
  - An aborted write never asserts dataMemWriteEnable.
  - chipSelect=1 coincident with the completing sclkPosEdge: abort wins.
- Back-to-back frames: one clk of chipSelect=1 is sufficient to restart at IDLE.
- sclkPosEdge pulses must be separated by at least 2 clk (guaranteed by the conditioner). Pulses closer together are still each counted.

## Test plan
- Reset mid-GET: reset=1 after 3 address edges with chipSelect=0 → next clk state=0, strobes 0; first edge after reset release is not counted until chipSelect has been seen low in IDLE.
- Write, width=8:
  - chipSelect=0, 8 edges, readWriteBit=0 → addressLatchEnable high for exactly 1 clk, state=5.
  - 8 more edges → dataMemWriteEnable high for exactly 1 clk, then state=7 until chipSelect=1, then state=0.
- Read, width=8, readWriteBit=1:
  - shiftRegWriteEnable is high from GOT+1 until the next edge.
  - misoBufferEnable is high from that edge through the 8th data edge, then state=7 with misoBufferEnable=0.
- Write abort: chipSelect=1 after 5 data edges → state=0 next clk; dataMemWriteEnable never asserts.
- Coincidence: chipSelect=1 on the same clk as the 8th address edge → state=0, addressLatchEnable never asserts. Edges while chipSelect=1 → state stays 0.
- Back-to-back: write frame, then chipSelect=1 for 1 clk, then read frame → both complete with the correct strobe sequences.

Source files
------------

// File: rtl/spi_control_fsm_if.sv
// Control bundle between the SPI transaction controller and its surroundings:
// conditioned inputs in, strobes and debug state out.
interface spi_control_fsm_if;
  logic       sclkPosEdge;
  logic       chipSelect;
  logic       readWriteBit;
  logic       shiftRegWriteEnable;
  logic       misoBufferEnable;
  logic       addressLatchEnable;
  logic       dataMemWriteEnable;
  logic [2:0] state;

  modport master (
    output sclkPosEdge, chipSelect, readWriteBit,
    input  shiftRegWriteEnable, misoBufferEnable, addressLatchEnable,
           dataMemWriteEnable, state
  );

  modport slave (
    input  sclkPosEdge, chipSelect, readWriteBit,
    output shiftRegWriteEnable, misoBufferEnable, addressLatchEnable,
           dataMemWriteEnable, state
  );
endinterface

// File: rtl/spi_control_fsm.sv
// SPI transaction controller: counts address/data bits on conditioned SCLK edges
// and issues Moore-decoded load, MISO-enable, address-latch and memory-write strobes.
module spi_control_fsm #(
  parameter int width = 8
) (
  input  logic                clk,
  input  logic                reset,
  spi_control_fsm_if.slave    bus
);

  localparam int CNT_W = $clog2(width + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(width - 1);
  // The load edge in READ_LOAD is data bit 1, so READ itself only sees width-1 edges.
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(width - 2);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET          = 3'd1,
    GOT          = 3'd2,
    READ_LOAD    = 3'd3,
    READ         = 3'd4,
    WRITE        = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.chipSelect) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = GET;
          cnt_d   = '0;
        end
        GET: begin
          if (bus.sclkPosEdge) begin
            if (cnt_q == FRAME_LAST) begin
              state_d = GOT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        GOT: begin
          state_d = bus.readWriteBit ? READ_LOAD : WRITE;
          cnt_d   = '0;
        end
        READ_LOAD: begin
          if (bus.sclkPosEdge) begin
            state_d = READ;
            cnt_d   = '0;
          end
        end
        READ: begin
          if (bus.sclkPosEdge) begin
            if (cnt_q == READ_LAST) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.sclkPosEdge) begin
            if (cnt_q == FRAME_LAST) begin
              state_d = WRITE_COMMIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WRITE_COMMIT: begin
          state_d = DONE;
          cnt_d   = '0;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Strobes decode the registered state only, so they are glitch-free and mutually exclusive.
  logic srwe, miso_en, ale, dmwe;

  always_comb begin
    srwe    = 1'b0;
    miso_en = 1'b0;
    ale     = 1'b0;
    dmwe    = 1'b0;
    unique case (state_q)
      GOT:          ale     = 1'b1;
      READ_LOAD:    srwe    = 1'b1;
      READ:         miso_en = 1'b1;
      WRITE_COMMIT: dmwe    = 1'b1;
      default: ;
    endcase
  end

  assign bus.shiftRegWriteEnable = srwe;
  assign bus.misoBufferEnable    = miso_en;
  assign bus.addressLatchEnable  = ale;
  assign bus.dataMemWriteEnable  = dmwe;
  assign bus.state               = state_q;

endmodule
